// File: rtl/instr_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit: bus widths, fetch FSM
// states and the {pc, instr} record carried through the fetch queue.
package instr_fetch_unit_pkg;

  localparam int ADDR_WIDTH = 32;
  localparam int DATA_WIDTH = 32;

  typedef enum logic {
    RUN   = 1'b0,
    FAULT = 1'b1
  } fetch_state_e;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] pc;
    logic [DATA_WIDTH-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/instr_fetch_unit_fetch_queue.sv
// Small FIFO of fetch entries. The pointers carry one extra wrap bit so that
// full and empty are told apart without an occupancy counter. The head is
// read combinationally from storage, so a push becomes visible the next cycle.
module fetch_queue
  import instr_fetch_unit_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t din,
  output fetch_entry_t dout,
  output logic         full,
  output logic         empty
);

  localparam int IW = $clog2(DEPTH);
  localparam logic [IW:0] PTR_ONE = 1;

  logic [IW:0]  rd_ptr;
  logic [IW:0]  wr_ptr;
  fetch_entry_t mem [DEPTH];

  assign empty = (rd_ptr == wr_ptr);
  assign full  = (rd_ptr[IW-1:0] == wr_ptr[IW-1:0]) && (rd_ptr[IW] != wr_ptr[IW]);
  assign dout  = mem[rd_ptr[IW-1:0]];

  // Pointer update; a flush empties the queue by catching rd up to wr.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else if (flush) begin
      rd_ptr <= wr_ptr;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // Entry storage; cleared on reset so the head reads as zero afterwards.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (push && !flush) begin
      mem[wr_ptr[IW-1:0]] <= din;
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, addresses instruction memory combinationally,
// queues {pc, instr} pairs and hands them to decode over valid/ready.
// A redirect from execute flushes the queue and restarts at the target.
// Optional macro FETCH_ALIGN_CHECK_EN: a misaligned redirect raises a sticky
// fetch_fault and parks the unit in FAULT until reset.
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = 32'h0000_0000,
  parameter int                    QDEPTH   = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  input  logic [DATA_WIDTH-1:0] imem_instr,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic                  if_valid,
  input  logic                  if_ready,
  output logic [ADDR_WIDTH-1:0] if_pc,
  output logic [DATA_WIDTH-1:0] if_instr,
  output logic                  fetch_fault
);

  localparam logic [ADDR_WIDTH-1:0] PC_STEP    = 4;
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = 3;

  logic [ADDR_WIDTH-1:0] pc;
  fetch_state_e          state;
  fetch_state_e          state_nx;
  logic                  redir;
  logic                  misalign;
  logic                  push;
  logic                  pop;
  logic                  q_full;
  logic                  q_empty;
  fetch_entry_t          q_in;
  fetch_entry_t          q_head;

  // Redirects are honoured only while running; FAULT ignores them.
  assign redir = redirect_valid && (state == RUN);

`ifdef FETCH_ALIGN_CHECK_EN
  assign misalign    = redir && ((redirect_pc & ALIGN_MASK) != '0);
  assign fetch_fault = (state == FAULT);
`else
  assign misalign    = 1'b0;
  assign fetch_fault = 1'b0;
`endif

  // A redirect cycle neither pushes nor pops; a full queue may still accept
  // a push when its head leaves in the same cycle.
  assign pop  = if_valid && if_ready && !redir;
  assign push = (state == RUN) && !redir && (!q_full || pop);

  assign imem_addr = pc;
  assign q_in.pc    = pc;
  assign q_in.instr = imem_instr;

  assign if_valid = !q_empty;
  assign if_pc    = q_head.pc;
  assign if_instr = q_head.instr;

  fetch_queue #(
    .DEPTH (QDEPTH)
  ) u_queue (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (redir),
    .din   (q_in),
    .dout  (q_head),
    .full  (q_full),
    .empty (q_empty)
  );

  // PC: redirect target (word aligned) wins, else advance on every push.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc <= RESET_PC;
    end else if (redir) begin
      if (!misalign) pc <= redirect_pc & ~ALIGN_MASK;
    end else if (push) begin
      pc <= pc + PC_STEP;
    end
  end

  // Fetch FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= RUN;
    else     state <= state_nx;
  end

  // Fetch FSM next state: a misaligned redirect is the only way into FAULT.
  always_comb begin
    state_nx = state;
    if (misalign) state_nx = FAULT;
  end

endmodule
